// File: rtl/right_shift_seq_if.sv
// Request/response bundle for the iterative right-shift unit.
// The datapath controller drives the master side; the shifter is the slave.
interface right_shift_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [WIDTH-1:0]   value_in;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, value_in, shamt, arith,
        input  busy, done, result
    );

    modport slave (
        input  start, value_in, shamt, arith,
        output busy, done, result
    );
endinterface

// File: rtl/right_shift_seq.sv
// Multi-cycle logical/arithmetic right shifter, up to STEP bits per cycle.
// start/busy/done handshake; result only updates on entry to DONE.
module right_shift_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic            clk,
    input  logic            reset,
    right_shift_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [SHAMT_W-1:0] LP_STEP = SHAMT_W'(STEP);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   w_work_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [SHAMT_W-1:0] r_rem;
    logic [SHAMT_W-1:0] w_rem_nxt;
    logic               r_fill;
    logic               w_fill_nxt;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_rem_sub;
    logic [WIDTH-1:0]   w_fill_mask;
    logic [WIDTH-1:0]   w_shifted;

    // A new op may start from DONE as well as IDLE, giving back-to-back issue
    assign w_accept    = bus.start && (r_state != S_SHIFT);
    assign w_k         = (r_rem < LP_STEP) ? r_rem : LP_STEP;
    assign w_rem_sub   = r_rem - w_k;
    assign w_fill_mask = r_fill ? ~({WIDTH{1'b1}} >> w_k) : '0;
    assign w_shifted   = (r_work >> w_k) | w_fill_mask;

    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_rem_nxt    = r_rem;
        w_fill_nxt   = r_fill;
        w_result_nxt = r_result;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    w_work_nxt = bus.value_in;
                    w_rem_nxt  = bus.shamt;
                    w_fill_nxt = bus.arith & bus.value_in[WIDTH-1];
                    if (bus.shamt == '0) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = bus.value_in;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_shifted;
                w_rem_nxt  = w_rem_sub;
                if (w_rem_sub == '0) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = w_shifted;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_rem    <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_work   <= w_work_nxt;
            r_rem    <= w_rem_nxt;
            r_fill   <= w_fill_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign bus.busy   = (r_state == S_SHIFT);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
endmodule

// File: tb/tb_right_shift_seq.sv
// Scoreboard bench: STEP=1 and STEP=4 shifters against an arithmetic model.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_right_shift_seq;
    typedef struct {
        logic [31:0] res;
        int          e;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    right_shift_seq_if #(.WIDTH(32), .SHAMT_W(5)) bus0 ();
    right_shift_seq_if #(.WIDTH(32), .SHAMT_W(5)) bus1 ();

    right_shift_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    right_shift_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    logic        s_start[2];
    logic [31:0] s_val[2];
    logic [4:0]  s_sh[2];
    logic        s_ar[2];
    logic        o_busy[2];
    logic        o_done[2];
    logic [31:0] o_res[2];

    assign bus0.start    = s_start[0];
    assign bus0.value_in = s_val[0];
    assign bus0.shamt    = s_sh[0];
    assign bus0.arith    = s_ar[0];
    assign bus1.start    = s_start[1];
    assign bus1.value_in = s_val[1];
    assign bus1.shamt    = s_sh[1];
    assign bus1.arith    = s_ar[1];
    assign o_busy[0]     = bus0.busy;
    assign o_done[0]     = bus0.done;
    assign o_res[0]      = bus0.result;
    assign o_busy[1]     = bus1.busy;
    assign o_done[1]     = bus1.done;
    assign o_res[1]      = bus1.result;

    // Reference model: op accepted at edge acc_n, done after edge acc_e
    bit          act[2];
    int          acc_n[2];
    int          acc_e[2];
    logic [31:0] cur_res[2];
    exp_t        q0[$];
    exp_t        q1[$];
    bit          chk_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] ref_shift(logic [31:0] v, logic [4:0] s, logic a);
        if (a) return 32'($signed(v) >>> s);
        return v >> s;
    endfunction

    function automatic int step_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit   eb;
                bit   ed;
                exp_t e;
                eb = act[i] && cyc >= acc_n[i] && cyc < acc_e[i];
                ed = act[i] && cyc == acc_e[i];
                check($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(eb));
                check($sformatf("done%0d", i), 32'(o_done[i]), 32'(ed));
                if (o_done[i] === 1'b1) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb%0d @edge %0d: done with no op outstanding", i, cyc);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check($sformatf("done_edge%0d", i), 32'(cyc), 32'(e.e));
                        cur_res[i] = e.res;
                    end
                end
                check($sformatf("result%0d", i), o_res[i], cur_res[i]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(int i, logic [31:0] v, logic [4:0] s, logic a);
        int   st;
        exp_t e;
        st = step_of(i);
        s_start[i] = 1'b1;
        s_val[i]   = v;
        s_sh[i]    = s;
        s_ar[i]    = a;
        if (!act[i] || cyc >= acc_e[i]) begin
            act[i]   = 1'b1;
            acc_n[i] = cyc + 1;
            acc_e[i] = cyc + 1 + (int'(s) + st - 1) / st;
            e.res    = ref_shift(v, s, a);
            e.e      = acc_e[i];
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic release_in(int i);
        s_start[i] = 1'b0;
        s_val[i]   = $urandom;
        s_sh[i]    = 5'($urandom);
        s_ar[i]    = 1'($urandom);
    endtask

    task automatic issue(int i, logic [31:0] v, logic [4:0] s, logic a);
        drive(i, v, s, a);
        step();
        release_in(i);
    endtask

    task automatic wait_ready(int i);
        for (int k = 0; k < 100; k++) begin
            if (!act[i] || cyc >= acc_e[i]) break;
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            act[i]     = 1'b0;
            cur_res[i] = '0;
        end
        q0.delete();
        q1.delete();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_start[i] = 1'b0;
            s_val[i]   = '0;
            s_sh[i]    = '0;
            s_ar[i]    = 1'b0;
            act[i]     = 1'b0;
            acc_n[i]   = 0;
            acc_e[i]   = 0;
            cur_res[i] = '0;
        end
        step();
        do_reset();
        chk_en = 1'b1;
        step();

        issue(0, 32'hF0F0F0F0, 5'd4, 1'b0);
        wait_ready(0);
        step();
        issue(0, 32'hF0000000, 5'd31, 1'b1);
        wait_ready(0);
        issue(0, 32'hF0000000, 5'd31, 1'b0);
        wait_ready(0);
        issue(0, 32'h80000000, 5'd31, 1'b0);
        wait_ready(0);
        step();
        issue(0, 32'hAAAAAAAA, 5'd0, 1'b0);
        wait_ready(0);
        step();

        issue(0, 32'h92345678, 5'd20, 1'b1);
        step();
        issue(0, 32'hFFFFFFFF, 5'd3, 1'b0);
        step();
        issue(0, 32'h0000FFFF, 5'd8, 1'b1);
        wait_ready(0);
        issue(0, 32'h20000000, 5'd29, 1'b0);
        wait_ready(0);
        step();

        issue(0, 32'h87654321, 5'd16, 1'b1);
        repeat (3) step();
        do_reset();
        repeat (4) step();
        issue(0, 32'h87654321, 5'd16, 1'b1);
        wait_ready(0);
        step();

        issue(1, 32'hFFFFFFFF, 5'd7, 1'b0);
        wait_ready(1);
        issue(1, 32'h80000001, 5'd31, 1'b1);
        wait_ready(1);
        issue(1, 32'h5A5A5A5A, 5'd0, 1'b1);
        wait_ready(1);
        step();

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        logic [4:0] s;
                        case ($urandom_range(0, 3))
                            0: s = 5'd0;
                            1: s = 5'd31;
                            default: s = 5'($urandom);
                        endcase
                        drive(i, $urandom, s, 1'($urandom));
                    end
                end
                step();
                release_in(0);
                release_in(1);
            end
        end

        wait_ready(0);
        wait_ready(1);
        repeat (2) step();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
